// File: rtl/sc_mult_seq.sv
// Sequencer for one stochastic-multiply run driven by an external 32-bit LFSR.
// Optional SC_BIPOLAR_EN adds a latched mode input selecting XNOR (bipolar) multiply.
module sc_mult_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value_a,
  input  logic [WIDTH-1:0] value_b,
  input  logic [LEN_W-1:0] stream_len,
`ifdef SC_BIPOLAR_EN
  input  logic             mode,
`endif
  input  logic [31:0]      lfsr_q,
  output logic             lfsr_reseed,
  output logic             lfsr_enable,
  output logic             sn_a,
  output logic             sn_b,
  output logic             sn_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] result
);

  typedef enum logic [1:0] {StIdle, StReseed, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] ones_q;
  logic             mode_q;
  logic             raw_a, raw_b, raw_prod;
  logic             accept;

  // Only the two comparator slices of the LFSR state are consumed.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q;

  assign accept = (state_q == StIdle) && start;

  always_comb begin
    state_d     = state_q;
    lfsr_reseed = 1'b0;
    lfsr_enable = 1'b0;
    bit_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StReseed;
      end
      StReseed: begin
        lfsr_reseed = 1'b1;
        busy        = 1'b1;
        state_d     = (rem_q == '0) ? StDone : StRun;
      end
      StRun: begin
        lfsr_enable = 1'b1;
        bit_valid   = 1'b1;
        busy        = 1'b1;
        if (rem_q == LEN_W'(1)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign raw_a = (lfsr_q[WIDTH-1:0] < a_q);
  assign raw_b = (lfsr_q[31 -: WIDTH] < b_q);

`ifdef SC_BIPOLAR_EN
  assign raw_prod = mode_q ? ~(raw_a ^ raw_b) : (raw_a & raw_b);
`else
  assign raw_prod = raw_a & raw_b;
  assign mode_q   = 1'b0;
  logic unused_mode;
  assign unused_mode = mode_q;
`endif

  assign sn_a   = bit_valid & raw_a;
  assign sn_b   = bit_valid & raw_b;
  assign sn_out = bit_valid & raw_prod;
  assign result = ones_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= value_a;
        b_q    <= value_b;
        rem_q  <= stream_len;
        ones_q <= '0;
      end else if (state_q == StRun) begin
        rem_q  <= rem_q - LEN_W'(1);
        ones_q <= ones_q + LEN_W'(sn_out);
      end
    end
  end

`ifdef SC_BIPOLAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (accept) begin
      mode_q <= mode;
    end
  end
`endif

endmodule

// File: tb/tb_sc_mult_seq.sv
// Directed self-checking bench for sc_mult_seq with a local 32-bit LFSR model.
// Define SC_BIPOLAR_EN to also exercise the XNOR multiply mode.
module tb_sc_mult_seq;

  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  value_a = '0;
  logic [7:0]  value_b = '0;
  logic [15:0] stream_len = '0;
  logic        mode = 1'b0;
  logic [31:0] lfsr_q;
  logic        lfsr_reseed, lfsr_enable, sn_a, sn_b, sn_out, bit_valid, busy, done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_mult_seq #(.WIDTH(8), .LEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .value_a    (value_a),
    .value_b    (value_b),
    .stream_len (stream_len),
`ifdef SC_BIPOLAR_EN
    .mode       (mode),
`endif
    .lfsr_q     (lfsr_q),
    .lfsr_reseed(lfsr_reseed),
    .lfsr_enable(lfsr_enable),
    .sn_a       (sn_a),
    .sn_b       (sn_b),
    .sn_out     (sn_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'hA300_0000) : (s >> 1);
  endfunction

  // External LFSR as the integrator wires it: reset = rst | lfsr_reseed.
  always_ff @(posedge clk) begin
    if (rst || lfsr_reseed) lfsr_q <= SEED;
    else if (lfsr_enable)   lfsr_q <= lfsr_step(lfsr_q);
  end

  function automatic int golden(input logic [7:0] a, input logic [7:0] b, input int len,
                                input logic m);
    logic [31:0] s;
    logic        sa, sb;
    int          cnt;
    s   = SEED;
    cnt = 0;
    for (int i = 0; i < len; i++) begin
      sa = (s[7:0] < a);
      sb = (s[31:24] < b);
      if (m ? ~(sa ^ sb) : (sa & sb)) cnt++;
      s = lfsr_step(s);
    end
    return cnt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One run from the start edge (edge 0) to a few idle cycles past done.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input int len, input logic m, input bit noise);
    int exp_res, reseeds, enables, valids, busys, dones, done_cyc, snerr;
    logic ea, eb, eo;
    exp_res  = golden(a, b, len, m);
    reseeds  = 0; enables = 0; valids = 0; busys = 0; dones = 0;
    done_cyc = -1; snerr = 0;
    @(negedge clk);
    value_a = a; value_b = b; stream_len = 16'(len); mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    value_a    = ~a;
    value_b    = 8'($urandom);
    stream_len = 16'($urandom);
    mode       = ~m;
    for (int k = 1; k <= len + 8; k++) begin
      @(negedge clk);
      reseeds += int'(lfsr_reseed);
      enables += int'(lfsr_enable);
      valids  += int'(bit_valid);
      busys   += int'(busy);
      if (done) begin
        dones++;
        done_cyc = k;
      end
      ea = lfsr_enable && (lfsr_q[7:0] < a);
      eb = lfsr_enable && (lfsr_q[31:24] < b);
      eo = lfsr_enable && (m ? ~(ea ^ eb) : (ea & eb));
      if (sn_a !== ea || sn_b !== eb || sn_out !== eo || bit_valid !== lfsr_enable) snerr++;
      start = noise && (k == 1 || k == 3 || k == len + 2);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, len + 2);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_reseeds"}, reseeds, 1);
    check({tag, "_enables"}, enables, len);
    check({tag, "_valids"}, valids, len);
    check({tag, "_busy_cycles"}, busys, len + 1);
    check({tag, "_sn_bits"}, snerr, 0);
    check({tag, "_result"}, 32'(result), exp_res);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_enable", 32'(lfsr_enable), 0);
    check("rst_reseed", 32'(lfsr_reseed), 0);
    check("rst_result", 32'(result), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset asserted in the middle of a run
    @(negedge clk);
    value_a = 8'd200; value_b = 8'd200; stream_len = 16'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_enable", 32'(lfsr_enable), 0);
    check("mid_valid", 32'(bit_valid), 0);
    check("mid_sn_out", 32'(sn_out), 0);
    check("mid_result", 32'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 8'd200, 8'd200, 50, 1'b0, 1'b0);

    run("a_zero", 8'd0, 8'd255, 100, 1'b0, 1'b0);
    check("a_zero_value", 32'(result), 0);

    run("len_zero", 8'd77, 8'd99, 0, 1'b0, 1'b0);

    run("full", 8'd255, 8'd255, 1000, 1'b0, 1'b0);
    check("full_range", 32'(result >= 16'd985 && result <= 16'd1000), 1);

    run("noise", 8'd128, 8'd64, 20, 1'b0, 1'b1);
    run("mixed", 8'd170, 8'd85, 37, 1'b0, 1'b0);

    // Result holds in IDLE while inputs wander
    value_a = 8'd1; value_b = 8'd2; stream_len = 16'd3;
    repeat (5) @(negedge clk);
    check("hold_result", 32'(result), golden(8'd170, 8'd85, 37, 1'b0));
    check("hold_busy", 32'(busy), 0);

`ifdef SC_BIPOLAR_EN
    run("xnor", 8'd128, 8'd128, 4096, 1'b1, 1'b0);
    check("xnor_range", 32'(result >= 16'd1848 && result <= 16'd2248), 1);
    run("and_mode", 8'd128, 8'd128, 64, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
